// File: rtl/fsm_arb_pkg.sv
// Shared types and widths for the round-robin command arbiter.
package fsm_arb_pkg;
  localparam int CMD_W   = 3;
  localparam int CNT_W   = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3
  } state_e;
endpackage

// File: rtl/fsm_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module fsm_arb_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_o,
  output logic             any_o
);
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;
  logic            found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = NREQ'({req_i, req_i} >> ptr_i);
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    win_o = NREQ'(({pick, pick} << ptr_i) >> NREQ);
  end

  assign any_o = |req_i;
endmodule

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter feeding one requester's command to a shared FSM.
// Optional FSM_ARB_LOCK_EN adds a lock input restricting IDLE arbitration to req[0].
module fsm_cmd_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMD_W-1:0] cmd,
`ifdef FSM_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [CMD_W-1:0]      fsm_user_input,
  output logic                  fsm_valid,
  input  logic [CMD_W-1:0]      fsm_out,
  output logic [CMD_W-1:0]      rsp_data,
  output logic                  rsp_valid,
  output logic                  err
);
  localparam int PTR_W = $clog2(NREQ);

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d, widx_q, win_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic [NREQ-1:0]    gnt_q, req_arb, win;
  logic               any;
  logic [CMD_W-1:0]   fui_q, win_cmd, rsp_data_q;
  logic               fsm_valid_q, rsp_valid_q, err_q;

`ifdef FSM_ARB_LOCK_EN
  assign req_arb = lock ? (req & NREQ'(1)) : req;
`else
  assign req_arb = req;
`endif

  fsm_arb_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req_i (req_arb),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any)
  );

  always_comb begin
    win_idx = '0;
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
      win_cmd = win_cmd | (cmd[i*CMD_W +: CMD_W] & {CMD_W{win[i]}});
    end
  end

  assign ptr_d = (widx_q == PTR_W'(NREQ-1)) ? '0 : widx_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      widx_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      fui_q       <= '0;
      fsm_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fsm_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q     <= GRANT;
            gnt_q       <= win;
            widx_q      <= win_idx;
            fui_q       <= win_cmd;
            fsm_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          state_q <= HOLD;
          cnt_q   <= CNT_W'(HOLD_CYCLES-1);
        end
        HOLD: begin
          // Winner dropping its request ends the hold early.
          if (!req[widx_q] || cnt_q == '0) begin
            state_q     <= RELEASE;
            gnt_q       <= '0;
            fui_q       <= '0;
            rsp_data_q  <= fsm_out;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          ptr_q   <= ptr_d;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          fui_q   <= '0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign fsm_user_input = fui_q;
  assign fsm_valid      = fsm_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign err            = err_q;
endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Bench for fsm_cmd_arbiter: directed corner cases plus a randomized scoreboard phase.
module tb_fsm_cmd_arbiter;
  import fsm_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int H    = 2;
  localparam int CW   = NREQ*3;

  logic            clk, rst_n;
  logic [NREQ-1:0] req, gnt;
  logic [CW-1:0]   cmd;
  logic [2:0]      fsm_user_input, fsm_out, rsp_data;
  logic            fsm_valid, rsp_valid, err;
  logic            lock;

  fsm_cmd_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd),
`ifdef FSM_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .fsm_user_input(fsm_user_input), .fsm_valid(fsm_valid),
    .fsm_out(fsm_out), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [2:0]      cmd;
    logic [2:0]      rsp;
    int              gap;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;

  // Round-robin reference: first requester at or after p, wrapping.
  function automatic int pick_model(input int p, input logic [NREQ-1:0] r);
    for (int off = 0; off < NREQ; off++)
      if (r[(p+off)%NREQ]) return (p+off)%NREQ;
    return -1;
  endfunction

  // Monitor: pops an expectation on each new command and checks its whole lifetime.
  exp_t cur;
  bit   active = 1'b0;
  bit   stable;
  int   t0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (fsm_valid) begin
        check("grant_expected", {31'd0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          check("sb_gnt", gnt, cur.gnt);
          check("sb_cmd", fsm_user_input, cur.cmd);
          t0 = cyc;
          active = 1'b1;
          stable = 1'b1;
        end
      end else if (active && !rsp_valid) begin
        if (gnt !== cur.gnt || fsm_user_input !== cur.cmd) stable = 1'b0;
      end
      if (rsp_valid) begin
        check("rsp_in_txn", {31'd0, active}, 32'd1);
        if (active) begin
          check("sb_rsp", rsp_data, cur.rsp);
          check("sb_rel_gnt", gnt, 0);
          check("sb_rel_cmd", fsm_user_input, 0);
          check("sb_gap", cyc - t0, cur.gap);
          check("sb_hold_stable", {31'd0, stable}, 32'd1);
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  int vcount, n, last_c, ptr_m, w, k;
  bit drop, seen, any_g;
  logic [NREQ-1:0] rq;
  logic [CW-1:0]   cv;
  exp_t e;

  initial begin
    rst_n = 1'b0; req = '0; cmd = '0; fsm_out = 3'd0; lock = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {gnt, fsm_user_input, fsm_valid, rsp_data, rsp_valid, err}, 0);
    check("rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;

    // Single request from requester 1, full hold, response captured on last HOLD cycle
    req = 4'b0010; cmd = '0; cmd[5:3] = 3'd5; fsm_out = 3'd2; vcount = 0;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0010);
    check("t1_valid", fsm_valid, 1);
    check("t1_cmd0", fsm_user_input, 5);
    vcount += int'(fsm_valid);
    @(negedge clk);
    check("t1_cmd1", fsm_user_input, 5);
    check("t1_gnt1", gnt, 4'b0010);
    vcount += int'(fsm_valid);
    @(negedge clk);
    check("t1_cmd2", fsm_user_input, 5);
    fsm_out = 3'd6;
    vcount += int'(fsm_valid);
    @(negedge clk);
    vcount += int'(fsm_valid);
    check("t1_state_rel", dut.state_q, RELEASE);
    check("t1_rel_gnt", gnt, 0);
    check("t1_rel_cmd", fsm_user_input, 0);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 6);
    check("t1_valid_once", vcount, 1);
    req = '0; fsm_out = 3'd1;
    @(negedge clk);
    check("t1_idle", dut.state_q, IDLE);
    check("t1_rsp_pulse", rsp_valid, 0);
    check("t1_rsp_hold", rsp_data, 6);

    // Early release: requester 2 drops during the first HOLD cycle
    req = 4'b0100;
    @(negedge clk);
    check("t2_gnt", gnt, 4'b0100);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check("t2_state_rel", dut.state_q, RELEASE);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_gnt", gnt, 0);
    @(negedge clk);

    // Reset mid-HOLD aborts; afterwards pointer restarts at 0
    req = 4'b1111;
    @(negedge clk);
    check("t3_gnt_ptr3", gnt, 4'b1000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t3_rst_outs", {gnt, fsm_user_input, fsm_valid, rsp_data, rsp_valid, err}, 0);
    check("t3_rst_state", dut.state_q, IDLE);
    @(negedge clk);
    check("t3_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;

    // All requests held: strict rotation, one transaction every H+3 cycles
    n = 0; last_c = 0;
    for (int t = 0; t < 60 && n < 8; t++) begin
      @(negedge clk);
      if (fsm_valid) begin
        check("t4_order", gnt, NREQ'(1) << (n % NREQ));
        if (n > 0) check("t4_period", cyc - last_c, H + 3);
        last_c = cyc;
        n++;
      end
    end
    check("t4_count", n, 8);
    req = '0;
    repeat (5) @(negedge clk);

    // Illegal state recovery
    force dut.state_q = state_e'(3'd6);
    #1 release dut.state_q;
    @(negedge clk);
    check("t5_state", dut.state_q, IDLE);
    check("t5_err", err, 1);
    check("t5_gnt", gnt, 0);
    check("t5_cmd", fsm_user_input, 0);
    @(negedge clk);
    check("t5_err_pulse", err, 0);

`ifdef FSM_ARB_LOCK_EN
    lock = 1'b1; req = 4'b1110; any_g = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt != '0 || fsm_valid) any_g = 1'b1;
    end
    check("lock_no_grant", {31'd0, any_g}, 0);
    req = '0; lock = 1'b0;
    @(negedge clk);
`endif

    // Randomized phase against the round-robin model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    mon_en = 1'b1;
    for (int r = 0; r < 60; r++) begin
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      cv = CW'($urandom);
      w = pick_model(ptr_m, rq);
      ptr_m = (w + 1) % NREQ;
      drop = 1'($urandom_range(0, 1));
      k = drop ? int'($urandom_range(1, H)) : H;
      e.gnt = NREQ'(1) << w;
      e.cmd = cv[w*3 +: 3];
      e.rsp = 3'($urandom_range(0, 7));
      e.gap = k + 1;
      q.push_back(e);
      req = rq; cmd = cv;
      fsm_out = e.rsp ^ 3'($urandom_range(1, 7));
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        @(negedge clk);
        seen = fsm_valid;
      end
      check("grant_seen", {31'd0, seen}, 1);
      for (int m = 1; m <= k; m++) begin
        @(negedge clk);
        req = (NREQ'($urandom) & ~e.gnt) | ((drop && m == k) ? '0 : e.gnt);
        cmd = CW'($urandom);
        if (m == k) fsm_out = e.rsp;
      end
      @(negedge clk);
    end
    req = '0;
    repeat (4) @(negedge clk);
    check("sb_empty", q.size(), 0);
    check("sb_idle", {31'd0, active}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fsm_cmd_arbiter.md
FSM_CMD_ARBITER -- requirements
Module: fsm_cmd_arbiter

Interface
REQ-001 SHALL provide parameter NREQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 2, meaning the number of cycles a granted command is held on the FSM input (legal range 1..15).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide port req, input, NREQ bits: per-requester request, level-sensitive.
REQ-006 SHALL provide port cmd, input, NREQ*3 bits: per-requester 3-bit command; requester i uses bits [3i+2:3i].
REQ-007 SHALL provide port lock, input, 1 bit: lock request (present only with FSM_ARB_LOCK_EN).
REQ-008 SHALL provide port gnt, output, NREQ bits: one-hot grant, or all zero.
REQ-009 SHALL provide port fsm_user_input, output, 3 bits: command driven to the shared FSM.
REQ-010 SHALL provide port fsm_valid, output, 1 bit: single-cycle strobe marking the first cycle of a new command.
REQ-011 SHALL provide port fsm_out, input, 3 bits: status returned by the shared FSM.
REQ-012 SHALL provide port rsp_data, output, 3 bits: fsm_out captured for the granted requester.
REQ-013 SHALL provide port rsp_valid, output, 1 bit: single-cycle strobe qualifying rsp_data.
REQ-014 SHALL provide port err, output, 1 bit: single-cycle strobe on illegal-state recovery.

Function
REQ-015 SHALL implement a 3-bit state register with legal states IDLE=0, GRANT=1, HOLD=2 and RELEASE=3.
REQ-016 In IDLE with any req bit set, SHALL select a winner round-robin, searching upward from pointer ptr and wrapping modulo NREQ, then go to GRANT.
REQ-017 SHALL assert gnt[winner] from the first cycle after IDLE through the last HOLD cycle, and clear it in RELEASE and IDLE.
REQ-018 SHALL register the winner's cmd on the IDLE->GRANT edge and hold fsm_user_input stable through HOLD; fsm_user_input SHALL be 0 in IDLE and RELEASE.
REQ-019 SHALL assert fsm_valid only in the GRANT cycle.
REQ-020 SHALL spend exactly HOLD_CYCLES cycles in HOLD using a 4-bit down-counter, then go to RELEASE.
REQ-021 If req[winner] is deasserted during HOLD, SHALL go to RELEASE on the next edge (early release).
REQ-022 SHALL sample fsm_out into rsp_data on the last HOLD cycle, and SHALL pulse rsp_valid in RELEASE; rsp_data SHALL hold its value until the next capture.
REQ-023 In RELEASE, SHALL set ptr to (winner+1) mod NREQ, then go to IDLE; every transaction therefore ends with at least one non-granted cycle.
REQ-024 Latency: a req first seen in IDLE at edge k SHALL produce gnt at edge k+1; with a full hold, a transaction SHALL occupy HOLD_CYCLES+3 cycles, IDLE included.
REQ-025 With all requests held, SHALL grant requesters in the order ptr, ptr+1, ..., with no requester starved for more than NREQ-1 transactions.
REQ-026 Changes to req or cmd from non-winning requesters during GRANT, HOLD or RELEASE SHALL be ignored.
REQ-027 Any state value 4..7 SHALL go to IDLE on the next edge, with gnt=0, fsm_user_input=0 and err pulsed for one cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, SHALL set state=IDLE, ptr=0, counter=0, and drive gnt, fsm_user_input, fsm_valid, rsp_data, rsp_valid and err to 0.
REQ-029 Reset asserted in any state, mid-transaction included, SHALL abort the transaction with no rsp_valid pulse.

Configuration
REQ-030 With macro FSM_ARB_LOCK_EN defined, and lock=1 sampled in IDLE, SHALL consider only req[0], and lock SHALL not affect a transaction already in progress.
REQ-031 Without FSM_ARB_LOCK_EN, the lock port SHALL be absent and arbitration SHALL follow REQ-016 unconditionally.

Structure
REQ-032 SHALL take the state encodings, CMD_W=3 and the counter width from shared package fsm_arb_pkg.
REQ-033 SHALL place winner selection in sub-module fsm_arb_rr_pick (combinational, inputs req and ptr, outputs a one-hot winner and an any flag).

Verification
REQ-034 Bench SHALL check: reset, then req=4'b0010 with cmd1=3'd5 -> gnt=4'b0010 one cycle later, fsm_valid pulses once, fsm_user_input=5 for 3 cycles, RELEASE then follows.
REQ-035 Bench SHALL check: req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Bench SHALL check: req[2] dropped on the first HOLD cycle -> RELEASE next cycle, with rsp_valid=1 and gnt=0.
REQ-037 Bench SHALL check: fsm_out=3'd6 on the last HOLD cycle -> rsp_data=6 with rsp_valid=1 in RELEASE.
REQ-038 Bench SHALL check: state forced to 3'd6 -> next cycle state=IDLE, err=1 for one cycle, gnt=0.
REQ-039 Bench SHALL check: rst_n=0 during HOLD -> all outputs 0 at the next edge, and after release of reset, req=4'b1111 is granted to requester 0 first; with FSM_ARB_LOCK_EN and lock=1, req=4'b1110 -> no grant.
